// File: rtl/booth_multiplier.sv
// Sequential signed multiplier, radix-4 modified Booth, one recoded digit per cycle.
// Partial products are accumulated through 8-bit carry-lookahead slices plus a 2-bit top extension.

module booth_cla8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] sum_c_o,
    output logic       cout_c_o
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       cc;
    logic       pr;

    // Each carry is formed directly from generate/propagate terms and the slice carry-in.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c  = '0;
        cc = 1'b0;
        pr = 1'b0;
        c[0] = c_i;
        for (int i = 0; i < 8; i++) begin
            cc = g[i];
            pr = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pr & g[j]);
                pr = pr & p[j];
            end
            c[i+1] = cc | (pr & c_i);
        end
        sum_c_o  = p ^ c[7:0];
        cout_c_o = c[8];
    end

endmodule

module booth_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned PW    = 2 * WIDTH + 3;
    localparam int unsigned NSL   = WIDTH / 8;
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic [AW-1:0]      acc;
    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      m2_ext;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      addend;
    logic               neg;
    logic [AW-1:0]      sum;
    logic [WIDTH-1:0]   sum_lo;
    logic [1:0]         sum_hi;
    logic [NSL:0]       carry;
    logic [PW-1:0]      step_prod;
    logic [WIDTH:0]     prod_hi;

    assign acc    = prod_q[PW-1:WIDTH+1];
    assign m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
    assign m2_ext = {m_q[WIDTH-1], m_q, 1'b0};

    // Booth digit select from {B[1], B[0], q_-1}.
    always_comb begin
        pp  = '0;
        neg = 1'b0;
        unique case (prod_q[2:0])
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m2_ext;
            3'b100: begin
                pp  = m2_ext;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = m_ext;
                neg = 1'b1;
            end
            default: pp = '0;
        endcase
    end

    // Subtraction = inverted operand with carry-in of one.
    assign addend   = neg ? ~pp : pp;
    assign carry[0] = neg;

    for (genvar k = 0; k < NSL; k++) begin : gen_slice
        booth_cla8 u_slice (
            .a_i      (acc[k*8 +: 8]),
            .b_i      (addend[k*8 +: 8]),
            .c_i      (carry[k]),
            .sum_c_o  (sum_lo[k*8 +: 8]),
            .cout_c_o (carry[k+1])
        );
    end

    assign sum_hi    = 2'(acc[AW-1:WIDTH] + addend[AW-1:WIDTH] + 2'(carry[NSL]));
    assign sum       = {sum_hi, sum_lo};
    assign step_prod = {{2{sum[AW-1]}}, sum, prod_q[WIDTH:2]};
    assign prod_hi   = prod_q[2*WIDTH:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        prod_d   = prod_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_MULT) begin
                    m_d     = data_operandA;
                    prod_d  = {AW'(0), data_operandB, 1'b0};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                prod_d = step_prod;
                cnt_d  = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = prod_q[WIDTH:1];
                exc_d    = ~((&prod_hi) | ~(|prod_hi));
                rdy_d    = 1'b1;
                state_d  = S_IDLE;
                // A new request here starts immediately, as from idle.
                if (ctrl_MULT) begin
                    m_d     = data_operandA;
                    prod_d  = {AW'(0), data_operandB, 1'b0};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier at WIDTH=32 with hand-computed products.

module tb_booth_multiplier;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

    booth_multiplier #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start at the next edge, scramble operands, then wait (bounded) for the pulse.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_e, input string tag);
        int n;
        bit seen;
        ctrl_MULT = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT = 1'b0;
        data_operandA = 32'hA5A5_5A5A;
        data_operandB = 32'h0F0F_F0F0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (data_resultRDY) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'd17);
        chk({tag, "_result"}, data_result, exp_r);
        chk({tag, "_exc"}, 32'(data_exception), 32'(exp_e));
        tick();
        chk({tag, "_rdy_low"}, 32'(data_resultRDY), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        int busy_bad;
        int rdy_bad;

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", 32'(data_exception), 32'd0);
        chk("reset_rdy", 32'(data_resultRDY), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Reset wins over a simultaneous start request.
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        tick();
        chk("reset_dominates_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        tick();
        chk("reset_dominates_idle", 32'(busy), 32'd0);

        // 3 x 5 with per-edge busy/rdy tracking.
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        tick();
        ctrl_MULT = 1'b0;
        chk("t1_busy_edge0", 32'(busy), 32'd1);
        busy_bad = 0;
        rdy_bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (busy !== 1'b1) busy_bad++;
            if (data_resultRDY !== 1'b0) rdy_bad++;
        end
        chk("t1_busy_run", 32'(busy_bad), 32'd0);
        chk("t1_rdy_early", 32'(rdy_bad), 32'd0);
        tick();
        chk("t1_rdy_edge17", 32'(data_resultRDY), 32'd1);
        chk("t1_busy_edge17", 32'(busy), 32'd0);
        chk("t1_result", data_result, 32'h0000_000F);
        chk("t1_exc", 32'(data_exception), 32'd0);
        tick();
        chk("t1_rdy_edge18", 32'(data_resultRDY), 32'd0);
        chk("t1_hold", data_result, 32'h0000_000F);

        do_mult(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, "neg7x6");
        do_mult(32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_002A, 1'b0, "neg7xneg6");
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxneg1");
        do_mult(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "minx1");
        do_mult(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "minxmin");

        // Second request during RUN must be ignored.
        ctrl_MULT = 1'b1;
        data_operandA = 32'h0001_2345;
        data_operandB = 32'h0000_0010;
        tick();
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        ctrl_MULT = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd9;
        tick();
        ctrl_MULT = 1'b0;
        for (int k = 6; k <= 16; k++) tick();
        chk("ign_rdy_edge16", 32'(data_resultRDY), 32'd0);
        tick();
        chk("ign_rdy_edge17", 32'(data_resultRDY), 32'd1);
        chk("ign_result", data_result, 32'h0012_3450);
        tick();
        rdy_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_bad++;
            tick();
        end
        chk("ign_no_second", 32'(rdy_bad), 32'd0);

        // Leave nonzero outputs behind so the abort clearing is visible.
        do_mult(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, "maxx2");

        // Reset at edge 8 aborts 1000 x 1000.
        ctrl_MULT = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd1000;
        tick();
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_result", data_result, 32'd0);
        chk("abort_exc", 32'(data_exception), 32'd0);
        chk("abort_rdy", 32'(data_resultRDY), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rdy_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (data_resultRDY !== 1'b0) rdy_bad++;
        end
        chk("abort_no_rdy", 32'(rdy_bad), 32'd0);
        do_mult(32'd10, 32'd10, 32'd100, 1'b0, "post_abort");

        // Back-to-back: new start during the RDY cycle of 2 x 3.
        ctrl_MULT = 1'b1;
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        tick();
        ctrl_MULT = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (data_resultRDY) seen = 1'b1;
        end
        chk("b2b_first_latency", 32'(n), 32'd17);
        chk("b2b_first_result", data_result, 32'd6);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        tick();
        ctrl_MULT = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (data_resultRDY) seen = 1'b1;
        end
        chk("b2b_second_latency", 32'(n), 32'd17);
        chk("b2b_second_result", data_result, 32'd16);
        chk("b2b_second_exc", 32'(data_exception), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
